user_conduit_front_panel: RTL and testbench
===========================================

// Module: user_conduit_front_panel
// PURPOSE
//  Board front-panel driver sitting directly upstream of the user_module conduit of amm_master_qsys_with_pcie.
//  Debounces KEYs, syncs SWs, builds a 28-bit address/data word and fires one n_action pulse per press.
//  After each transaction it captures display_data and shows it on the eight seven-segment digits.
//  debug_flag is mirrored to the red LEDs.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  consecutive stable cycles before a key changes debounced state (10 ms @ 50 MHz)
//  PULSE_CYCLES     4       cycles n_action is held low per transaction (>=1)
//  WAIT_CYCLES      1024    cycles after pulse release before display_data is captured (>=1)
// PORTS
//  clk_clk                          in   1   system clock, shared with the Qsys clk_clk
//  reset_reset_n                    in   1   asynchronous active-low reset
//  key_n                            in   2   raw pushbuttons, active low; [0]=action, [1]=load word
//  sw                               in   18  raw switches; [17]=rdwr_cntl, [16]=add_data_sel, [15:0]=entry value
//  user_module_conduit_rdwr_cntl    out  1   registered sw[17], frozen while busy
//  user_module_conduit_n_action     out  1   active-low action strobe
//  user_module_conduit_add_data_sel out  1   registered sw[16], frozen while busy
//  user_module_conduit_rdwr_address out  28  assembled address/data word
//  user_module_conduit_debug_flag   in   16  status from user module
//  user_module_conduit_display_data in   32  result word from user module
//  hex_n                            out  56  8 digits x 7 segments, active low; digit i = hex_n[7i+6:7i]
//  ledr                             out  16  registered debug_flag
//  busy                             out  1   high whenever FSM is not IDLE
// BEHAVIOUR
//  Reset values: n_action=1, rdwr_cntl=0, add_data_sel=0, rdwr_address=0, disp_reg=0, ledr=0, busy=0.
//  Reset values (cont.): FSM=IDLE, debounced keys=released; hex_n shows "00000000" (each digit 7'b1000000).
//  Sync: key_n and sw each pass through a 2-FF synchroniser; nothing reads the raw inputs.
//  Debounce: counter resets whenever the sync'd key differs from the debounced state.
//  Debounce (cont.): debounced state flips when counter reaches DEBOUNCE_CYCLES-1.
//  Debounce (cont.): a press event is a 1-cycle pulse on the debounced 1->0 edge; release produces no event.
//  Load (key1 press, IDLE only): rdwr_address <= {rdwr_address[11:0], sw_s[15:0]}.
//  Load (cont.): two presses give a full 28-bit word (upper 4 bits of the first entry are dropped).
//  Mode bits: in IDLE, rdwr_cntl/add_data_sel track sw_s[17]/sw_s[16] every cycle.
//  Mode bits (cont.): rdwr_cntl, add_data_sel and rdwr_address are frozen in every other state.
//  FSM: IDLE -key0 press-> PULSE: n_action=0 for exactly PULSE_CYCLES cycles; n_action is a registered output.
//  FSM (cont.): PULSE -> WAIT: n_action=1 for WAIT_CYCLES cycles.
//  FSM (cont.): WAIT -> CAPTURE: disp_reg <= display_data, 1 cycle -> IDLE.
//  Latency: key0 debounced edge -> n_action low = 1 cycle; press -> new hex = 1+PULSE+WAIT+1 cycles.
//  Presses while busy: ignored, not queued; this applies to key0 and key1.
//  Simultaneous key0+key1 events in IDLE: load is applied and the transaction starts on the same edge.
//  Simultaneous events (cont.): the transaction carries the newly loaded word.
//  Counters: a single phase counter, sized clog2(max(PULSE,WAIT)), cleared on every state entry; no wrap reachable.
//  Reset mid-transaction: returns to IDLE immediately, n_action=1 asynchronously; no glitch low.
//  Hex: digit i shows disp_reg[4i+3:4i] as 0-F (standard a-g patterns, A b C d E F), combinational from disp_reg.
//  ledr: registered copy of debug_flag, updated every cycle.
// STRUCTURE
//  Package front_panel_pkg: state enum {IDLE,PULSE,WAIT,CAPTURE}.
//  Package (cont.): function hex7_n(nibble) returning 7-bit active-low pattern; constant SEG_ZERO_N=7'b1000000.
//  Sub-module key_debounce (sync + counter + press pulse), instantiated twice.
//  Sub-module parameter: DEBOUNCE_CYCLES.
//  Top holds sw sync, address shifter, FSM, disp_reg, hex decode.
// TESTING  (bench uses DEBOUNCE_CYCLES=8, PULSE_CYCLES=4, WAIT_CYCLES=16)
//  Reset: all outputs at reset values; hex_n = {8{7'b1000000}}; busy=0.
//  Bounce: key0 toggled every 3 cycles for 30 cycles, then held low.
//  Bounce (expect): exactly one n_action pulse, 4 cycles low; none during bouncing.
//  Load: sw[15:0]=16'h1234, key1; then 16'hABCD, key1 -> rdwr_address=28'h234ABCD.
//  Transaction: sw[17:16]=2'b10, display_data=32'hDEADBEEF, key0.
//  Transaction (expect): n_action low 4 cycles, rdwr_cntl=1 throughout.
//  Transaction (expect, cont.): 16 cycles later hex digits show D E A d b E E F; busy drops in the next cycle.
//  Busy lockout: key0 and key1 pressed during WAIT.
//  Busy lockout (expect): no second pulse; rdwr_address unchanged; sw[17] flip not seen until IDLE.
//  Reset mid-PULSE: assert reset_reset_n=0 on 2nd low cycle -> n_action=1 same cycle, FSM IDLE, disp_reg=0.

Source files
------------

// File: rtl/front_panel_pkg.sv
// Shared types and helpers for the front-panel driver: FSM state encoding,
// key indices, word widths and the seven-segment decoder.
package front_panel_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  localparam int ADDR_W   = 28;
  localparam int ENTRY_W  = 16;
  localparam int DIGITS   = 8;
  localparam int KEY_ACT  = 0;
  localparam int KEY_LOAD = 1;

  // Digit "0", active low, segment order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_ZERO_N = 7'b1000000;

  // Hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7_n(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = SEG_ZERO_N;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/user_conduit_front_panel_key_debounce.sv
// One pushbutton: 2-FF synchroniser, stability counter and a single-cycle
// press pulse on the debounced released->pressed transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             db_n;
  logic [CNT_W-1:0] cnt;

  // Bring the raw button into the clock domain; idle level is released (1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
    end
  end

  // Count consecutive cycles that disagree with the debounced level; flip
  // after DEBOUNCE_CYCLES of them and flag a press only on the falling flip
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_n  <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_p1 == db_n) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db_n  <= sync_p1;
        cnt   <= '0;
        press <= ~sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/user_conduit_front_panel.sv
// Front-panel driver for the user_module conduit: debounced keys build a
// 28-bit address/data word and launch one n_action strobe per press; the
// returned display_data is latched and shown on eight hex digits.
module user_conduit_front_panel
  import front_panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PULSE_CYCLES    = 4,
  parameter int WAIT_CYCLES     = 1024
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [1:0]          key_n,
  input  logic [17:0]         sw,
  output logic                user_module_conduit_rdwr_cntl,
  output logic                user_module_conduit_n_action,
  output logic                user_module_conduit_add_data_sel,
  output logic [ADDR_W-1:0]   user_module_conduit_rdwr_address,
  input  logic [15:0]         user_module_conduit_debug_flag,
  input  logic [31:0]         user_module_conduit_display_data,
  output logic [7*DIGITS-1:0] hex_n,
  output logic [15:0]         ledr,
  output logic                busy
);

  // One phase counter serves both timed states; it restarts on every entry
  localparam int PHASE_MAX = (PULSE_CYCLES > WAIT_CYCLES) ? PULSE_CYCLES : WAIT_CYCLES;
  localparam int PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
  localparam logic [PHASE_W-1:0] PULSE_LAST = PHASE_W'(PULSE_CYCLES - 1);
  localparam logic [PHASE_W-1:0] WAIT_LAST  = PHASE_W'(WAIT_CYCLES - 1);

  logic [17:0]        sw_p0;
  logic [17:0]        sw_p1;
  logic               press_act;
  logic               press_load;
  state_t             state;
  logic [PHASE_W-1:0] phase;
  logic [31:0]        disp_reg;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_act (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .key_n (key_n[KEY_ACT]),
    .press (press_act)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_load (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .key_n (key_n[KEY_LOAD]),
    .press (press_load)
  );

  // Two-stage synchroniser for the slide switches
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= sw;
      sw_p1 <= sw_p0;
    end
  end

  // Transaction FSM; mode bits and the word only move while IDLE, so a
  // load and a start on the same edge send the freshly loaded word
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state                            <= IDLE;
      phase                            <= '0;
      busy                             <= 1'b0;
      user_module_conduit_n_action     <= 1'b1;
      user_module_conduit_rdwr_cntl    <= 1'b0;
      user_module_conduit_add_data_sel <= 1'b0;
      user_module_conduit_rdwr_address <= '0;
      disp_reg                         <= '0;
    end else begin
      case (state)
        IDLE: begin
          user_module_conduit_rdwr_cntl    <= sw_p1[17];
          user_module_conduit_add_data_sel <= sw_p1[16];
          if (press_load) begin
            user_module_conduit_rdwr_address <=
              {user_module_conduit_rdwr_address[ADDR_W-ENTRY_W-1:0], sw_p1[ENTRY_W-1:0]};
          end
          if (press_act) begin
            state                        <= PULSE;
            phase                        <= '0;
            busy                         <= 1'b1;
            user_module_conduit_n_action <= 1'b0;
          end
        end
        PULSE: begin
          if (phase == PULSE_LAST) begin
            state                        <= WAIT;
            phase                        <= '0;
            user_module_conduit_n_action <= 1'b1;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        WAIT: begin
          if (phase == WAIT_LAST) begin
            state <= CAPTURE;
            phase <= '0;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        CAPTURE: begin
          disp_reg <= user_module_conduit_display_data;
          state    <= IDLE;
          phase    <= '0;
          busy     <= 1'b0;
        end
        default: begin
          state                        <= IDLE;
          phase                        <= '0;
          busy                         <= 1'b0;
          user_module_conduit_n_action <= 1'b1;
        end
      endcase
    end
  end

  // Status LEDs mirror the user module's debug flags one cycle late
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ledr <= '0;
    end else begin
      ledr <= user_module_conduit_debug_flag;
    end
  end

  // Each digit decodes its own nibble of the captured result
  always_comb begin
    hex_n = '1;
    for (int i = 0; i < DIGITS; i++) begin
      hex_n[7*i +: 7] = hex7_n(disp_reg[4*i +: 4]);
    end
  end

endmodule

// File: tb/tb_user_conduit_front_panel.sv
// Self-checking bench for user_conduit_front_panel with a short debounce.
module tb_user_conduit_front_panel;

  localparam int DEB   = 8;
  localparam int PUL   = 4;
  localparam int WT    = 16;
  localparam int WT_LK = 64;

  logic        clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [1:0]  key_n = 2'b11;
  logic [1:0]  key_lk_n = 2'b11;
  logic [17:0] sw = '0;
  logic [15:0] debug_flag = '0;
  logic [31:0] display_data = '0;

  logic        rdwr_cntl, n_action, add_data_sel, busy;
  logic [27:0] rdwr_address;
  logic [55:0] hex_n;
  logic [15:0] ledr;

  logic        lk_rdwr_cntl, lk_n_action, lk_add_data_sel, lk_busy;
  logic [27:0] lk_rdwr_address;
  logic [55:0] lk_hex_n;
  logic [15:0] lk_ledr;

  always #5 clk = ~clk;

  user_conduit_front_panel #(
    .DEBOUNCE_CYCLES(DEB), .PULSE_CYCLES(PUL), .WAIT_CYCLES(WT)
  ) dut (
    .clk_clk                          (clk),
    .reset_reset_n                    (reset_reset_n),
    .key_n                            (key_n),
    .sw                               (sw),
    .user_module_conduit_rdwr_cntl    (rdwr_cntl),
    .user_module_conduit_n_action     (n_action),
    .user_module_conduit_add_data_sel (add_data_sel),
    .user_module_conduit_rdwr_address (rdwr_address),
    .user_module_conduit_debug_flag   (debug_flag),
    .user_module_conduit_display_data (display_data),
    .hex_n                            (hex_n),
    .ledr                             (ledr),
    .busy                             (busy)
  );

  // Second instance with a long WAIT so a full re-press of key0 fits inside one transaction
  user_conduit_front_panel #(
    .DEBOUNCE_CYCLES(DEB), .PULSE_CYCLES(PUL), .WAIT_CYCLES(WT_LK)
  ) dut_lk (
    .clk_clk                          (clk),
    .reset_reset_n                    (reset_reset_n),
    .key_n                            (key_lk_n),
    .sw                               (sw),
    .user_module_conduit_rdwr_cntl    (lk_rdwr_cntl),
    .user_module_conduit_n_action     (lk_n_action),
    .user_module_conduit_add_data_sel (lk_add_data_sel),
    .user_module_conduit_rdwr_address (lk_rdwr_address),
    .user_module_conduit_debug_flag   (debug_flag),
    .user_module_conduit_display_data (display_data),
    .hex_n                            (lk_hex_n),
    .ledr                             (lk_ledr),
    .busy                             (lk_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference seven-segment model: lit segments listed by letter
  string seg_tbl [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                          "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] seg_n(input string s);
    logic [6:0] r;
    r = '1;
    for (int i = 0; i < s.len(); i++) begin
      int idx;
      idx = int'(s[i]) - 97;
      r[idx] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [55:0] exp_hex(input logic [31:0] v);
    logic [55:0] r;
    for (int i = 0; i < 8; i++) r[7*i +: 7] = seg_n(seg_tbl[v[4*i +: 4]]);
    return r;
  endfunction

  // Pulse monitor on the main instance
  int          pulse_cnt = 0;
  int          cur_len = 0;
  int          last_len = 0;
  logic        prev_n = 1'b1;
  logic [27:0] pulse_addr = '0;
  logic        pulse_cntl = 1'b0;
  logic        pulse_ads = 1'b0;
  logic        pulse_stable = 1'b1;

  always @(negedge clk) begin
    if (n_action === 1'b0) begin
      if (prev_n) begin
        pulse_cnt    <= pulse_cnt + 1;
        cur_len      <= 1;
        pulse_addr   <= rdwr_address;
        pulse_cntl   <= rdwr_cntl;
        pulse_ads    <= add_data_sel;
        pulse_stable <= 1'b1;
      end else begin
        cur_len <= cur_len + 1;
        if (rdwr_cntl !== pulse_cntl || rdwr_address !== pulse_addr) pulse_stable <= 1'b0;
      end
    end else if (!prev_n) begin
      last_len <= cur_len;
    end
    prev_n <= n_action;
  end

  int   lk_pulse_cnt = 0;
  logic lk_prev = 1'b1;
  always @(negedge clk) begin
    if (lk_prev && lk_n_action === 1'b0) lk_pulse_cnt <= lk_pulse_cnt + 1;
    lk_prev <= lk_n_action;
  end

  // Reference model state
  logic [27:0] m_addr = '0;
  logic [31:0] m_disp = '0;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_n(input logic lvl, input int lim, input string tag);
    int k = 0;
    while (n_action !== lvl && k < lim) begin
      @(negedge clk);
      k++;
    end
    check_val(tag, 64'(n_action), 64'(lvl));
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_val(tag, 64'(busy), 64'd0);
  endtask

  task automatic press_keys(input logic [1:0] mask);
    key_n = key_n & ~mask;
    cycles(DEB + 4);
    key_n = key_n | mask;
    cycles(DEB + 4);
  endtask

  // One load and/or transaction, checked against the model
  task automatic do_op(input logic [1:0] mask, input logic [17:0] swv, input logic [31:0] dd);
    int p0;
    sw = swv;
    display_data = dd;
    cycles(4);
    check_val("mode_cntl", 64'(rdwr_cntl), 64'(swv[17]));
    check_val("mode_ads", 64'(add_data_sel), 64'(swv[16]));
    p0 = pulse_cnt;
    press_keys(mask);
    wait_idle("op_idle");
    cycles(2);
    if (mask[1]) m_addr = {m_addr[11:0], swv[15:0]};
    if (mask[0]) m_disp = dd;
    check_val("op_addr", 64'(rdwr_address), 64'(m_addr));
    check_val("op_hex", 64'(hex_n), 64'(exp_hex(m_disp)));
    check_val("op_npulse", 64'(pulse_cnt - p0), 64'(mask[0]));
    if (mask[0]) begin
      check_val("op_len", 64'(last_len), 64'(PUL));
      check_val("op_pulse_addr", 64'(pulse_addr), 64'(m_addr));
      check_val("op_pulse_cntl", 64'(pulse_cntl), 64'(swv[17]));
      check_val("op_pulse_ads", 64'(pulse_ads), 64'(swv[16]));
      check_val("op_stable", 64'(pulse_stable), 64'd1);
    end
  endtask

  initial begin
    int          p0;
    logic [31:0] dd;
    logic [27:0] a0;

    // Reset state
    cycles(3);
    check_val("rst_n_action", 64'(n_action), 64'd1);
    check_val("rst_cntl", 64'(rdwr_cntl), 64'd0);
    check_val("rst_ads", 64'(add_data_sel), 64'd0);
    check_val("rst_addr", 64'(rdwr_address), 64'd0);
    check_val("rst_hex", 64'(hex_n), 64'(exp_hex(32'h0)));
    check_val("rst_ledr", 64'(ledr), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    reset_reset_n = 1'b1;
    cycles(2);

    // LED mirror
    for (int i = 0; i < 3; i++) begin
      debug_flag = 16'($urandom);
      cycles(1);
      check_val("ledr", 64'(ledr), 64'(debug_flag));
    end

    // Two loads assemble a full word
    do_op(2'b10, {2'b00, 16'h1234}, 32'h0);
    do_op(2'b10, {2'b00, 16'hABCD}, 32'h0);
    check_val("load_word", 64'(rdwr_address), 64'h234ABCD);

    // Directed transaction with exact capture timing
    sw = {2'b10, 16'h0000};
    display_data = 32'hDEADBEEF;
    cycles(4);
    p0 = pulse_cnt;
    key_n[0] = 1'b0;
    wait_n(1'b0, 40, "tx_start");
    key_n[0] = 1'b1;
    wait_n(1'b1, 10, "tx_release");
    cycles(WT);
    check_val("tx_hex_before", 64'(hex_n), 64'(exp_hex(m_disp)));
    check_val("tx_busy_before", 64'(busy), 64'd1);
    cycles(1);
    m_disp = 32'hDEADBEEF;
    check_val("tx_hex", 64'(hex_n), 64'(exp_hex(m_disp)));
    check_val("tx_busy_after", 64'(busy), 64'd0);
    cycles(DEB + 6);
    check_val("tx_npulse", 64'(pulse_cnt - p0), 64'd1);
    check_val("tx_len", 64'(last_len), 64'(PUL));
    check_val("tx_cntl", 64'(pulse_cntl), 64'd1);
    check_val("tx_stable", 64'(pulse_stable), 64'd1);

    // Bouncing key0: nothing until it settles, then a single pulse
    dd = $urandom;
    display_data = dd;
    sw = 18'($urandom);
    cycles(4);
    p0 = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      key_n[0] = ~key_n[0];
      cycles(3);
    end
    check_val("bounce_quiet", 64'(pulse_cnt - p0), 64'd0);
    key_n[0] = 1'b0;
    wait_n(1'b0, 40, "bounce_start");
    wait_n(1'b1, 10, "bounce_end");
    key_n[0] = 1'b1;
    wait_idle("bounce_idle");
    cycles(DEB + 6);
    m_disp = dd;
    check_val("bounce_npulse", 64'(pulse_cnt - p0), 64'd1);
    check_val("bounce_len", 64'(last_len), 64'(PUL));
    check_val("bounce_hex", 64'(hex_n), 64'(exp_hex(m_disp)));

    // Key1 and a mode change during WAIT are ignored until IDLE
    dd = $urandom;
    display_data = dd;
    sw = {2'b00, 16'($urandom)};
    cycles(4);
    p0 = pulse_cnt;
    a0 = m_addr;
    key_n[0] = 1'b0;
    wait_n(1'b0, 40, "lock_start");
    key_n[0] = 1'b1;
    wait_n(1'b1, 10, "lock_wait");
    sw = {2'b10, 16'($urandom)};
    key_n[1] = 1'b0;
    cycles(DEB + 4);
    check_val("lock_busy", 64'(busy), 64'd1);
    check_val("lock_cntl_frozen", 64'(rdwr_cntl), 64'd0);
    key_n[1] = 1'b1;
    wait_idle("lock_idle");
    cycles(1);
    check_val("lock_cntl_idle", 64'(rdwr_cntl), 64'd1);
    check_val("lock_addr", 64'(rdwr_address), 64'(a0));
    cycles(DEB + 6);
    m_disp = dd;
    check_val("lock_npulse", 64'(pulse_cnt - p0), 64'd1);
    check_val("lock_hex", 64'(hex_n), 64'(exp_hex(m_disp)));

    // Key0 re-pressed while busy on the long-WAIT instance
    begin
      int k = 0;
      key_lk_n[0] = 1'b0;
      while (lk_n_action !== 1'b0 && k < 40) begin
        @(negedge clk);
        k++;
      end
      check_val("lk_start", 64'(lk_n_action), 64'd0);
      key_lk_n[0] = 1'b1;
      cycles(DEB + 6);
      key_lk_n[0] = 1'b0;
      cycles(DEB + 4);
      check_val("lk_busy", 64'(lk_busy), 64'd1);
      key_lk_n[0] = 1'b1;
      k = 0;
      while (lk_busy !== 1'b0 && k < 200) begin
        @(negedge clk);
        k++;
      end
      check_val("lk_idle", 64'(lk_busy), 64'd0);
      cycles(DEB + 6);
      check_val("lk_npulse", 64'(lk_pulse_cnt), 64'd1);
      check_val("lk_addr", 64'(lk_rdwr_address), 64'd0);
      check_val("lk_hex", 64'(lk_hex_n), 64'(exp_hex(display_data)));
      check_val("lk_ledr", 64'(lk_ledr), 64'(debug_flag));
      check_val("lk_cntl", 64'(lk_rdwr_cntl), 64'(sw[17]));
      check_val("lk_ads", 64'(lk_add_data_sel), 64'(sw[16]));
    end

    // Randomized loads, transactions and simultaneous presses
    for (int it = 0; it < 10; it++) begin
      logic [1:0] mask;
      mask = 2'($urandom_range(1, 3));
      debug_flag = 16'($urandom);
      do_op(mask, 18'($urandom), $urandom);
      check_val("rnd_ledr", 64'(ledr), 64'(debug_flag));
    end

    // Reset asserted on the second low cycle of n_action
    sw = 18'($urandom);
    display_data = $urandom;
    cycles(4);
    key_n[0] = 1'b0;
    wait_n(1'b0, 40, "mid_start");
    @(posedge clk);
    #1 reset_reset_n = 1'b0;
    #1;
    check_val("mid_n_action", 64'(n_action), 64'd1);
    check_val("mid_busy", 64'(busy), 64'd0);
    check_val("mid_hex", 64'(hex_n), 64'(exp_hex(32'h0)));
    check_val("mid_addr", 64'(rdwr_address), 64'd0);
    key_n = 2'b11;
    cycles(3);
    reset_reset_n = 1'b1;
    m_addr = '0;
    m_disp = '0;
    cycles(DEB + 8);
    check_val("post_n_action", 64'(n_action), 64'd1);
    check_val("post_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
